// File: rtl/pwm_peripheral.sv
// pwm_peripheral: sixteen output channels driven low, static high, or by one shared 256-step PWM.
// Optional macro PWM_SHADOW_EN latches the duty cycle only at period boundaries (glitch-free updates).
module pwm_peripheral #(
    parameter int PRESCALE_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic             period_start_q, period_start_d;
    logic [15:0]      out_q, out_d;

    logic             tick;
    logic             boundary;
    logic             pwm_level;
    logic [7:0]       duty_eff;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick     = (pre_cnt_q == PRE_MAX);
    assign boundary = tick && (pwm_cnt_q == 8'hFF);

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    // Duty is only sampled on the period boundary so a write never cuts a pulse short.
    always_comb begin
        duty_d = duty_q;
        if (boundary) begin
            duty_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // Full scale is special-cased so 0xFF means solid high rather than 255/256.
    assign pwm_level = (duty_eff == 8'hFF) || (pwm_cnt_q < duty_eff);

    always_comb begin
        pre_cnt_d      = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_start_d = boundary;
        out_d          = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'h00;
            period_start_q <= 1'b0;
            out_q          <= 16'h0000;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: randomized and directed checks of pwm_peripheral against a time-based reference model.
// Honours PWM_SHADOW_EN the same way as the design build.
module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  en_reg_out_7_0  = 8'h00;
    logic [7:0]  en_reg_out_15_8 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0  = 8'h00;
    logic [7:0]  en_reg_pwm_15_8 = 8'h00;
    logic [7:0]  pwm_duty_cycle  = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    pwm_peripheral #(.PRESCALE_DIV(P)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    wire [15:0] en_out = {en_reg_out_15_8, en_reg_out_7_0};
    wire [15:0] en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Reference: elapsed clocks since reset release give the PWM step as (n / P) mod 256.
    int unsigned n_edges;
    logic [7:0]  model_duty;
    logic [15:0] exp_out;
    logic        exp_ps;

    always @(posedge clk or posedge rst) begin : ref_model
        int unsigned step;
        logic [7:0]  d;
        logic        lvl;
        if (rst) begin
            n_edges    = 0;
            model_duty = 8'h00;
            exp_out    = 16'h0000;
            exp_ps     = 1'b0;
        end else begin
            step = (n_edges / P) % 256;
`ifdef PWM_SHADOW_EN
            d = model_duty;
`else
            d = pwm_duty_cycle;
`endif
            lvl = (d == 8'hFF) ? 1'b1 : (step < int'(d));
            for (int i = 0; i < 16; i++) begin
                exp_out[i] = en_out[i] ? (en_pwm[i] ? lvl : 1'b1) : 1'b0;
            end
            n_edges = n_edges + 1;
            exp_ps  = ((n_edges % PERIOD) == 0);
            if (exp_ps) begin
                model_duty = pwm_duty_cycle;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_enables(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
    endtask

    task automatic wait_ps(output bit found);
        found = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_enables(16'($urandom), 16'($urandom));
            pwm_duty_cycle = 8'($urandom);
            @(negedge clk);
            checks++;
            if (out !== 16'h0000 || period_start !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold out=%h ps=%b required out=0000 ps=0", out, period_start);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release out=%h ps=%b required out=0000 ps=0", out, period_start);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL reset_after out=%h ps=%b required out=%h ps=%b", out, period_start, exp_out, exp_ps);
            end
        end
    endtask

    task automatic test_static_enable();
        set_enables(16'h0000, 16'h0000);
        pwm_duty_cycle = 8'($urandom);
        do_reset();
        @(negedge clk);
        en_reg_out_7_0 = 8'hA5;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL static_latency out=%h required 0000", out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 16'h00A5 || out !== exp_out) begin
                errors++;
                $display("[TB] FAIL static_a5 out=%h required 00a5 (model %h)", out, exp_out);
            end
        end
        en_reg_out_15_8 = 8'h3C;
        @(negedge clk);
        checks++;
        if (out !== 16'h3CA5) begin
            errors++;
            $display("[TB] FAIL static_3ca5 out=%h required 3ca5", out);
        end
    endtask

    task automatic test_pwm_50();
        bit   found;
        logic cur_val;
        int   cur_len, highs, ps_cnt, last_ps;
        bit   first_run;
        set_enables(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        do_reset();
        wait_ps(found);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL pwm50_ps_timeout found=0 required 1");
        end
        cur_val = out[0]; cur_len = 1; first_run = 1'b1;
        highs = 0; ps_cnt = 0; last_ps = 0;
        for (int c = 1; c <= 2 * PERIOD + 1; c++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL pwm50_model c=%0d out=%h ps=%b required out=%h ps=%b", c, out, period_start, exp_out, exp_ps);
            end
            if (out[0] === cur_val) begin
                cur_len++;
            end else begin
                if (!first_run) begin
                    checks++;
                    if (cur_len != PERIOD / 2) begin
                        errors++;
                        $display("[TB] FAIL pwm50_run c=%0d len=%0d required %0d", c, cur_len, PERIOD / 2);
                    end
                end
                first_run = 1'b0;
                cur_val   = out[0];
                cur_len   = 1;
            end
            if (c <= 2 * PERIOD) begin
                if (out[0] === 1'b1) highs++;
                if (period_start === 1'b1) begin
                    ps_cnt++;
                    checks++;
                    if (c - last_ps != PERIOD) begin
                        errors++;
                        $display("[TB] FAIL pwm50_ps_spacing gap=%0d required %0d", c - last_ps, PERIOD);
                    end
                    last_ps = c;
                end
            end
        end
        checks++;
        if (highs != PERIOD || ps_cnt != 2) begin
            errors++;
            $display("[TB] FAIL pwm50_totals highs=%0d ps=%0d required highs=%0d ps=2", highs, ps_cnt, PERIOD);
        end
    endtask

    task automatic test_extremes();
        bit          found;
        int          bad;
        logic [7:0]  duties [2] = '{8'h00, 8'hFF};
        logic [15:0] want;
        for (int k = 0; k < 2; k++) begin
            set_enables(16'hFFFF, 16'hFFFF);
            pwm_duty_cycle = duties[k];
            want = (duties[k] == 8'hFF) ? 16'hFFFF : 16'h0000;
            do_reset();
            wait_ps(found);
            checks++;
            if (!found) begin
                errors++;
                $display("[TB] FAIL extreme_ps_timeout duty=%h found=0 required 1", duties[k]);
            end
            bad = 0;
            for (int c = 1; c <= 2 * PERIOD; c++) begin
                @(negedge clk);
                if (out !== want) bad++;
                checks++;
                if (out !== exp_out || period_start !== exp_ps) begin
                    errors++;
                    $display("[TB] FAIL extreme_model duty=%h c=%0d out=%h required %h", duties[k], c, out, exp_out);
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL extreme_const duty=%h wrong_cycles=%0d required 0", duties[k], bad);
            end
        end
    endtask

    task automatic test_shadow();
        bit found;
        int h1, h2;
        set_enables(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        do_reset();
        wait_ps(found);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL shadow_ps_timeout found=0 required 1");
        end
        h1 = 0; h2 = 0;
        for (int c = 1; c <= 2 * PERIOD; c++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL shadow_model c=%0d out=%h ps=%b required out=%h ps=%b", c, out, period_start, exp_out, exp_ps);
            end
            if (out[5] === 1'b1) begin
                if (c <= PERIOD) h1++; else h2++;
            end
            if (c == 8'h20 * P) pwm_duty_cycle = 8'hC0;
        end
        checks++;
`ifdef PWM_SHADOW_EN
        if (h1 != 64 * P || h2 != 192 * P) begin
            errors++;
            $display("[TB] FAIL shadow_widths h1=%0d h2=%0d required %0d %0d", h1, h2, 64 * P, 192 * P);
        end
`else
        if (h1 != 192 * P || h2 != 192 * P) begin
            errors++;
            $display("[TB] FAIL shadow_widths h1=%0d h2=%0d required %0d %0d", h1, h2, 192 * P, 192 * P);
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit found;
        int ps_at;
        set_enables(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        do_reset();
        wait_ps(found);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL midrst_ps_timeout found=0 required 1");
        end
        for (int c = 1; c <= 8'h60 * P; c++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL midrst_model c=%0d out=%h required %h", c, out, exp_out);
            end
        end
        checks++;
        if (out !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL midrst_pre out=%h required ffff", out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async out=%h ps=%b required out=0000 ps=0", out, period_start);
        end
        @(negedge clk);
        rst   = 1'b0;
        ps_at = -1;
        for (int c = 1; c <= PERIOD + 2; c++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL midrst_after c=%0d out=%h ps=%b required out=%h ps=%b", c, out, period_start, exp_out, exp_ps);
            end
            if (period_start === 1'b1 && ps_at < 0) ps_at = c;
        end
        checks++;
        if (ps_at != PERIOD) begin
            errors++;
            $display("[TB] FAIL midrst_ps_delay got=%0d required %0d", ps_at, PERIOD);
        end
    endtask

    task automatic test_random();
        set_enables(16'($urandom), 16'($urandom));
        pwm_duty_cycle = 8'($urandom);
        do_reset();
        for (int c = 1; c <= 2 * PERIOD + 100; c++) begin
            @(negedge clk);
            checks++;
            if (out !== exp_out || period_start !== exp_ps) begin
                errors++;
                $display("[TB] FAIL random_model c=%0d out=%h ps=%b required out=%h ps=%b", c, out, period_start, exp_out, exp_ps);
            end
            if ($urandom_range(199) == 0) set_enables(16'($urandom), 16'($urandom));
            if ($urandom_range(299) == 0) pwm_duty_cycle = 8'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_static_enable();
        test_pwm_50();
        test_extremes();
        test_shadow();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
